uvma_mapu_sched: RTL

- Two-requester scheduler that shares one Matrix APU (MAPU) between two job sources.
- Arbitrates at whole-job granularity and sequences each job's input rows into the MAPU data-in port.
- Drives the MAPU control inputs (en, op) and routes result rows, tagged with requester ID and overflow, back on a shared response stream.
- Sits between the requester fabric and the MAPU; it is the MAPU's only master.

---
 rtl/uvma_mapu_sched.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/uvma_mapu_sched.sv
// Two-requester job scheduler in front of a single Matrix APU: whole-job arbitration, row feeding, tagged result return.
// Optional watchdog (output err_timeout, parameter TIMEOUT_CYCLES) is compiled in with `define UVMA_MAPU_SCHED_TIMEOUT_EN.
module uvma_mapu_sched #(
    parameter int DATA_WIDTH = 32,
    parameter int IN_ROWS    = 8,
    parameter int OUT_ROWS   = 4,
    parameter int MAX_OUTST  = 2
`ifdef UVMA_MAPU_SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req0_vld,
    output logic                    req0_rdy,
    input  logic                    req0_op,
    input  logic [4*DATA_WIDTH-1:0] req0_row,
    input  logic                    req1_vld,
    output logic                    req1_rdy,
    input  logic                    req1_op,
    input  logic [4*DATA_WIDTH-1:0] req1_row,
    output logic                    mapu_en,
    output logic                    mapu_op,
    input  logic                    mapu_of,
    output logic                    mapu_i_vld,
    input  logic                    mapu_o_rdy,
    output logic [4*DATA_WIDTH-1:0] mapu_i_row,
    input  logic                    mapu_o_vld,
    output logic                    mapu_i_rdy,
    input  logic [4*DATA_WIDTH-1:0] mapu_o_row,
    output logic                    rsp_vld,
    input  logic                    rsp_rdy,
    output logic                    rsp_id,
    output logic                    rsp_last,
    output logic                    rsp_of,
    output logic [4*DATA_WIDTH-1:0] rsp_row,
`ifdef UVMA_MAPU_SCHED_TIMEOUT_EN
    output logic                    err_timeout,
`endif
    output logic                    busy
);

    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int IW = (IN_ROWS > 1) ? $clog2(IN_ROWS) : 1;
    localparam int CW = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;
    localparam logic [OW-1:0] OUTST_MAX = OW'(MAX_OUTST);
    localparam logic [IW-1:0] IN_LAST   = IW'(IN_ROWS - 1);
    localparam logic [CW-1:0] OUT_LAST  = CW'(OUT_ROWS - 1);

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_FEED} state_t;

    state_t               state, state_nxt;
    logic                 grant, grant_nxt;
    logic                 rr_ptr, rr_ptr_nxt;
    logic                 pend_op, pend_op_nxt;
    logic                 op_q, op_nxt;
    logic                 en_q, en_nxt;
    logic [IW-1:0]        in_cnt, in_cnt_nxt;
    logic [CW-1:0]        out_cnt;
    logic [OW-1:0]        outst;
    logic                 of_acc;
    logic [MAX_OUTST-1:0] id_fifo, id_fifo_nxt;
    logic                 any_vld, pick, pick_op, blocked, push, pop;
    logic                 fifo_nempty, ret_xfer, ret_last;

    assign mapu_op     = op_q;
    assign mapu_en     = en_q;
    assign fifo_nempty = (outst != '0);
    assign rsp_vld     = mapu_o_vld & fifo_nempty;
    assign mapu_i_rdy  = rsp_rdy & fifo_nempty;
    assign ret_xfer    = rsp_vld & rsp_rdy;
    assign ret_last    = (out_cnt == OUT_LAST);
    assign pop         = ret_xfer & ret_last;
    assign rsp_last    = rsp_vld & ret_last;
    assign rsp_of      = rsp_vld & (of_acc | mapu_of);
    assign rsp_row     = mapu_o_row;
    assign rsp_id      = id_fifo[0];
    assign busy        = (state != S_IDLE) | fifo_nempty;

    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        rr_ptr_nxt  = rr_ptr;
        pend_op_nxt = pend_op;
        op_nxt      = op_q;
        en_nxt      = en_q;
        in_cnt_nxt  = in_cnt;
        push        = 1'b0;
        mapu_i_vld  = 1'b0;
        mapu_i_row  = '0;
        req0_rdy    = 1'b0;
        req1_rdy    = 1'b0;
        any_vld     = req0_vld | req1_vld;
        pick        = (req0_vld && req1_vld) ? rr_ptr : req1_vld;
        pick_op     = pick ? req1_op : req0_op;
        case (state)
            S_IDLE: begin
                if (!any_vld && outst == '0)
                    en_nxt = 1'b0;
                if (any_vld && outst != OUTST_MAX && !blocked) begin
                    grant_nxt   = pick;
                    pend_op_nxt = pick_op;
                    en_nxt      = 1'b1;
                    // An op change must wait until every job of the old op has fully returned.
                    if (pick_op != op_q && outst != '0) begin
                        state_nxt = S_DRAIN;
                    end else begin
                        op_nxt    = pick_op;
                        state_nxt = S_FEED;
                    end
                end
            end
            S_DRAIN: begin
                if (outst == '0) begin
                    op_nxt    = pend_op;
                    state_nxt = S_FEED;
                end
            end
            S_FEED: begin
                mapu_i_vld = grant ? req1_vld : req0_vld;
                mapu_i_row = grant ? req1_row : req0_row;
                req0_rdy   = !grant && mapu_o_rdy;
                req1_rdy   = grant && mapu_o_rdy;
                if (mapu_i_vld && mapu_o_rdy) begin
                    if (in_cnt == IN_LAST) begin
                        in_cnt_nxt = '0;
                        push       = 1'b1;
                        rr_ptr_nxt = ~grant;
                        state_nxt  = S_IDLE;
                    end else begin
                        in_cnt_nxt = in_cnt + IW'(1);
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Head of the ID FIFO is bit 0; a pop shifts down, so a same-cycle push lands one slot lower.
    always_comb begin
        id_fifo_nxt = pop ? (id_fifo >> 1) : id_fifo;
        for (int i = 0; i < MAX_OUTST; i++)
            if (push && i == int'(outst) - int'(pop))
                id_fifo_nxt[i] = grant;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            grant   <= 1'b0;
            rr_ptr  <= 1'b0;
            pend_op <= 1'b0;
            op_q    <= 1'b0;
            en_q    <= 1'b0;
            in_cnt  <= '0;
            out_cnt <= '0;
            outst   <= '0;
            of_acc  <= 1'b0;
            id_fifo <= '0;
        end else begin
            state   <= state_nxt;
            grant   <= grant_nxt;
            rr_ptr  <= rr_ptr_nxt;
            pend_op <= pend_op_nxt;
            op_q    <= op_nxt;
            en_q    <= en_nxt;
            in_cnt  <= in_cnt_nxt;
            id_fifo <= id_fifo_nxt;
            case ({push, pop})
                2'b10:   outst <= outst + OW'(1);
                2'b01:   outst <= outst - OW'(1);
                default: ;
            endcase
            if (ret_xfer) begin
                out_cnt <= ret_last ? '0 : out_cnt + CW'(1);
                of_acc  <= ret_last ? 1'b0 : (of_acc | mapu_of);
            end
        end
    end

`ifdef UVMA_MAPU_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt;

    // Watchdog counts cycles with work outstanding but no result progress; once tripped it stops new grants.
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt      <= '0;
            err_timeout <= 1'b0;
        end else if (!fifo_nempty || ret_xfer) begin
            to_cnt <= '0;
        end else if (!err_timeout) begin
            to_cnt <= to_cnt + TW'(1);
            if (to_cnt == TW'(TIMEOUT_CYCLES - 1))
                err_timeout <= 1'b1;
        end
    end

    assign blocked = err_timeout;
`else
    assign blocked = 1'b0;
`endif

endmodule
